// File: rtl/arm_pipelined_mem_pkg.sv
// Shared types and constants for the pipelined CPU memory-port arbiter.
// Exports: state_e (IDLE/FETCH/DATA), owner_e (OWNER_FETCH/OWNER_DATA),
//          STARVE_LIMIT_DEFAULT and the starvation counter width CNT_W.
package arm_pipelined_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int STARVE_LIMIT_DEFAULT = 4;
  // Wide enough for the full 1..15 range of STARVE_LIMIT.
  localparam int CNT_W = 4;

endpackage

// File: rtl/arm_pipelined_mem_arbiter.sv
// Arbitrates one variable-latency memory port between Fetch (instruction reads)
// and Memory stage (LDR/STR); registered memory request, one-cycle valid pulses.
// Ports: i_CLK/i_NRESET; Fetch req/addr/flush -> instr/valid; Data req/write/addr/wdata
//        -> rdata/valid; stall outputs; o_Mem_* request bus with i_Mem_Ready/i_Mem_RData.
import arm_pipelined_mem_pkg::*;

module arm_pipelined_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                  i_CLK,
  input  logic                  i_NRESET,
  input  logic                  i_Fetch_Req,
  input  logic [ADDR_WIDTH-1:0] i_Fetch_Addr,
  output logic [DATA_WIDTH-1:0] o_Fetch_Instr,
  output logic                  o_Fetch_Valid,
  input  logic                  i_Flush_Fetch,
  input  logic                  i_Data_Req,
  input  logic                  i_Data_Write,
  input  logic [ADDR_WIDTH-1:0] i_Data_Addr,
  input  logic [DATA_WIDTH-1:0] i_Data_WData,
  output logic [DATA_WIDTH-1:0] o_Data_RData,
  output logic                  o_Data_Valid,
  output logic                  o_Stall_Fetch,
  output logic                  o_Stall_Memory,
  output logic                  o_Mem_Req,
  output logic                  o_Mem_Write,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [DATA_WIDTH-1:0] o_Mem_WData,
  input  logic                  i_Mem_Ready,
  input  logic [DATA_WIDTH-1:0] i_Mem_RData
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  discard_q, discard_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
  logic                  data_valid_q, data_valid_d;

  // A transaction completes on any edge where the request is up and memory is ready.
  // Grants are evaluated in IDLE and in the completion cycle so back-to-back
  // transactions run without a bubble.
  logic   complete;
  logic   grant_eval;
  logic   grant_vld;
  owner_e grant_owner;

  always_comb begin
    complete    = (state_q != IDLE) && i_Mem_Ready;
    grant_eval  = (state_q == IDLE) || complete;
    grant_vld   = grant_eval && (i_Fetch_Req || i_Data_Req);
    // Data has priority unless fetch has been passed over STARVE_LIMIT times.
    grant_owner = (i_Data_Req && !(i_Fetch_Req && (starve_q == LIMIT))) ? OWNER_DATA
                                                                         : OWNER_FETCH;
  end

  // State register
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (grant_eval) begin
      if (!grant_vld)                     state_d = IDLE;
      else if (grant_owner == OWNER_DATA) state_d = DATA;
      else                                state_d = FETCH;
    end
  end

  // Output logic: next values of registered outputs plus combinational stalls
  always_comb begin
    mem_req_d     = mem_req_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_instr_d = fetch_instr_q;
    fetch_valid_d = 1'b0;
    data_rdata_d  = data_rdata_q;
    data_valid_d  = 1'b0;
    discard_d     = discard_q;
    starve_d      = starve_q;

    if (state_q == FETCH && complete) begin
      // A flush in the completion cycle itself also drops the result.
      if (!discard_q && !i_Flush_Fetch) begin
        fetch_instr_d = i_Mem_RData;
        fetch_valid_d = 1'b1;
      end
      discard_d = 1'b0;
    end else if (state_q == FETCH && i_Flush_Fetch) begin
      discard_d = 1'b1;
    end

    if (state_q == DATA && complete) begin
      data_valid_d = 1'b1;
      if (!mem_write_q) data_rdata_d = i_Mem_RData;
    end

    if (grant_eval) begin
      if (!grant_vld) begin
        mem_req_d   = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
      end else if (grant_owner == OWNER_DATA) begin
        mem_req_d   = 1'b1;
        mem_write_d = i_Data_Write;
        mem_addr_d  = i_Data_Addr;
        mem_wdata_d = i_Data_WData;
        if (i_Fetch_Req && starve_q != LIMIT) starve_d = starve_q + 1'b1;
      end else begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b0;
        mem_addr_d  = i_Fetch_Addr;
        mem_wdata_d = '0;
        starve_d    = '0;
      end
    end
    if (!i_Fetch_Req) starve_d = '0;

    o_Stall_Memory = i_Data_Req && !(state_q == DATA && i_Mem_Ready);
    o_Stall_Fetch  = o_Stall_Memory ||
                     (i_Fetch_Req && !(state_q == FETCH && i_Mem_Ready &&
                                       !discard_q && !i_Flush_Fetch));
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      starve_q      <= '0;
      discard_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_instr_q <= '0;
      fetch_valid_q <= 1'b0;
      data_rdata_q  <= '0;
      data_valid_q  <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      discard_q     <= discard_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_valid_q <= fetch_valid_d;
      data_rdata_q  <= data_rdata_d;
      data_valid_q  <= data_valid_d;
    end
  end

  assign o_Mem_Req     = mem_req_q;
  assign o_Mem_Write   = mem_write_q;
  assign o_Mem_Addr    = mem_addr_q;
  assign o_Mem_WData   = mem_wdata_q;
  assign o_Fetch_Instr = fetch_instr_q;
  assign o_Fetch_Valid = fetch_valid_q;
  assign o_Data_RData  = data_rdata_q;
  assign o_Data_Valid  = data_valid_q;

  // The owner must keep its request up until the cycle in which memory is ready.
  a_fetch_held: assert property (@(posedge i_CLK) disable iff (!i_NRESET)
    (state_q == FETCH && !i_Mem_Ready) |-> i_Fetch_Req);
  a_data_held: assert property (@(posedge i_CLK) disable iff (!i_NRESET)
    (state_q == DATA && !i_Mem_Ready) |-> i_Data_Req);

endmodule

// File: tb/tb_arm_pipelined_mem_arbiter.sv
// Self-checking bench for arm_pipelined_mem_arbiter: directed scenarios plus
// protocol-legal random traffic, compared every cycle against a transaction-level model.
module tb_arm_pipelined_mem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        fr, fl, dr, dw, rdy;
  logic [31:0] fa, da, wd, rd;
  logic [31:0] f_instr, d_rdata, m_addr, m_wdata;
  logic        f_valid, d_valid, st_f, st_m, m_req, m_write;

  always #5 clk = ~clk;

  arm_pipelined_mem_arbiter dut (
    .i_CLK(clk), .i_NRESET(nrst),
    .i_Fetch_Req(fr), .i_Fetch_Addr(fa),
    .o_Fetch_Instr(f_instr), .o_Fetch_Valid(f_valid),
    .i_Flush_Fetch(fl),
    .i_Data_Req(dr), .i_Data_Write(dw), .i_Data_Addr(da), .i_Data_WData(wd),
    .o_Data_RData(d_rdata), .o_Data_Valid(d_valid),
    .o_Stall_Fetch(st_f), .o_Stall_Memory(st_m),
    .o_Mem_Req(m_req), .o_Mem_Write(m_write), .o_Mem_Addr(m_addr), .o_Mem_WData(m_wdata),
    .i_Mem_Ready(rdy), .i_Mem_RData(rd)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, who owns it, and what it carries.
  bit          m_busy, m_is_data, m_discard;
  int          m_starve;
  bit          e_req, e_write, e_fv, e_dv;
  logic [31:0] e_addr, e_wdata, e_instr, e_rdata;

  task automatic model_reset();
    m_busy = 0; m_is_data = 0; m_discard = 0; m_starve = 0;
    e_req = 0; e_write = 0; e_fv = 0; e_dv = 0;
    e_addr = 0; e_wdata = 0; e_instr = 0; e_rdata = 0;
  endtask

  task automatic model_edge();
    bit done;
    done = m_busy && rdy;
    e_fv = 0;
    e_dv = 0;
    if (m_busy && !m_is_data) begin
      if (done) begin
        if (!(m_discard || fl)) begin e_instr = rd; e_fv = 1; end
        m_discard = 0;
      end else if (fl) m_discard = 1;
    end
    if (done && m_is_data) begin
      e_dv = 1;
      if (!e_write) e_rdata = rd;
    end
    if (!m_busy || done) begin
      if (dr && !(fr && m_starve == LIM)) begin
        m_busy = 1; m_is_data = 1;
        e_req = 1; e_write = dw; e_addr = da; e_wdata = wd;
        if (fr && m_starve < LIM) m_starve++;
      end else if (fr) begin
        m_busy = 1; m_is_data = 0;
        e_req = 1; e_write = 0; e_addr = fa; e_wdata = 0;
        m_starve = 0;
      end else begin
        m_busy = 0; e_req = 0; e_write = 0; e_addr = 0; e_wdata = 0;
      end
    end
    if (!fr) m_starve = 0;
  endtask

  task automatic check_outputs();
    chk("mem_req", m_req, e_req);
    chk("mem_write", m_write, e_write);
    chk("mem_addr", m_addr, e_addr);
    chk("mem_wdata", m_wdata, e_wdata);
    chk("fetch_valid", f_valid, e_fv);
    if (e_fv) chk("fetch_instr", f_instr, e_instr);
    chk("data_valid", d_valid, e_dv);
    chk("data_rdata", d_rdata, e_rdata);
  endtask

  task automatic step(input bit i_fr, input logic [31:0] i_fa, input bit i_fl,
                      input bit i_dr, input bit i_dw, input logic [31:0] i_da,
                      input logic [31:0] i_wd, input bit i_rdy, input logic [31:0] i_rd);
    bit exp_sm, exp_sf;
    @(negedge clk);
    fr = i_fr; fa = i_fa; fl = i_fl; dr = i_dr; dw = i_dw; da = i_da; wd = i_wd;
    rdy = i_rdy; rd = i_rd;
    #1;
    exp_sm = dr && !(m_busy && m_is_data && rdy);
    exp_sf = exp_sm || (fr && !(m_busy && !m_is_data && rdy && !m_discard && !fl));
    chk("stall_mem", st_m, exp_sm);
    chk("stall_fetch", st_f, exp_sf);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (m_busy && n < 10) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_0000);
      n++;
    end
    if (m_busy) chk("drain_timeout", 1, 0);
  endtask

  logic [31:0] t4_exp [6];

  initial begin
    int wait_cnt;
    bit r_fr, r_dr, r_rdy;

    t4_exp[0] = 32'h300; t4_exp[1] = 32'h300; t4_exp[2] = 32'h300;
    t4_exp[3] = 32'h300; t4_exp[4] = 32'h50;  t4_exp[5] = 32'h300;

    fr = 0; fa = 0; fl = 0; dr = 0; dw = 0; da = 0; wd = 0; rdy = 0; rd = 0;
    nrst = 0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    nrst = 1;

    // Fetch only, two wait cycles
    step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_req", m_req, 1);
    step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h10, 0, 0, 0, 0, 0, 1, 32'hE3A01005);
    chk("t1_valid", f_valid, 1);
    chk("t1_instr", f_instr, 32'hE3A01005);
    chk("t1_idle", m_req, 0);

    // Store and fetch in the same cycle: data goes first
    step(1, 32'h20, 0, 1, 1, 32'h100, 32'hDEADBEEF, 0, 0);
    chk("t2_write", m_write, 1);
    chk("t2_wdata", m_wdata, 32'hDEADBEEF);
    step(1, 32'h20, 0, 0, 1, 32'h100, 32'hDEADBEEF, 1, 0);
    chk("t2_dvalid", d_valid, 1);
    chk("t2_fetch_addr", m_addr, 32'h20);
    step(0, 32'h20, 0, 0, 0, 0, 0, 1, 32'h11112222);
    drain();

    // Flush while a fetch is in flight
    step(1, 32'h30, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h30, 1, 0, 0, 0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'hAAAA5555);
    chk("t3_dropped", f_valid, 0);
    chk("t3_new_pc", m_addr, 32'h40);
    step(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    step(0, 32'h40, 0, 0, 0, 0, 0, 1, 32'hE1A00000);
    chk("t3_valid", f_valid, 1);
    chk("t3_instr", f_instr, 32'hE1A00000);
    drain();

    // Starvation: data held with fetch pending
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h50, 0, 1, 0, 32'h300, 0, 1, 32'h1000 + i);
      chk($sformatf("t4_grant%0d", i), m_addr, t4_exp[i]);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drain();

    // Load with memory ready immediately
    step(0, 0, 0, 1, 0, 32'h200, 0, 1, 0);
    step(0, 0, 0, 0, 0, 32'h200, 0, 1, 32'h12345678);
    chk("t6_dvalid", d_valid, 1);
    chk("t6_rdata", d_rdata, 32'h12345678);
    drain();

    // Asynchronous reset in the middle of a data transaction
    step(0, 0, 0, 1, 1, 32'h400, 32'h5A5A5A5A, 0, 0);
    chk("t5_req_before", m_req, 1);
    @(negedge clk);
    rdy = 0;
    #2 nrst = 0;
    #1;
    chk("t5_req_async", m_req, 0);
    model_reset();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
    nrst = 1; dr = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random protocol-legal traffic
    wait_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      r_rdy = (wait_cnt >= 3) || ($urandom_range(0, 2) == 0);
      if (m_busy && !r_rdy) wait_cnt++;
      else wait_cnt = 0;
      r_fr = (m_busy && !m_is_data && !r_rdy) ? 1'b1 : ($urandom_range(0, 9) < 7);
      r_dr = (m_busy && m_is_data && !r_rdy) ? 1'b1 : 1'($urandom_range(0, 1));
      step(r_fr, $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 7) == 0),
           r_dr, 1'($urandom_range(0, 1)), $urandom, $urandom, r_rdy, $urandom);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
